// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: sequential reads into a small FIFO that feeds IF/ID; J flushes and redirects.
// Build option IF_PREFETCH_STATS_EN adds saturating flush / empty-pop event counters.
module if_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          PC_STEP  = 4,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     LE,
   input  logic                     J,
   input  logic [7:0]               TA,
   output logic                     IMEM_RD,
   output logic [7:0]               IMEM_ADDR,
   input  logic [31:0]              IMEM_DATA,
   output logic [7:0]               front_address,
   output logic [31:0]              fetched_instruction,
   output logic                     VALID,
`ifdef IF_PREFETCH_STATS_EN
   output logic [15:0]              STAT_FLUSHES,
   output logic [15:0]              STAT_EMPTY,
`endif
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [7:0]    r_pc;
   logic          r_inflight;
   logic [7:0]    r_inflight_addr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_mem_data [DEPTH];
   logic [7:0]    r_mem_addr [DEPTH];

   logic [CW:0]   w_occ;
   logic          w_issue;
   logic          w_valid;
   logic          w_push;
   logic          w_pop;

   // A request is only issued when its FIFO slot is already guaranteed, so pushes never overflow.
   assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue = !RST && !J && (w_occ < DEPTH_W);
   assign w_valid = (r_count != '0);
   assign w_push  = r_inflight;
   assign w_pop   = LE && w_valid;

   assign IMEM_RD             = w_issue;
   assign IMEM_ADDR           = r_pc;
   assign VALID               = w_valid;
   assign COUNT               = r_count;
   assign front_address       = w_valid ? r_mem_addr[r_rd_ptr] : r_pc;
   assign fetched_instruction = w_valid ? r_mem_data[r_rd_ptr] : NOP_WORD;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc            <= '0;
         r_inflight      <= 1'b0;
         r_inflight_addr <= '0;
         r_rd_ptr        <= '0;
         r_wr_ptr        <= '0;
         r_count         <= '0;
      end else if (J) begin
         // the in-flight response belongs to the abandoned path and is dropped
         r_pc       <= TA;
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc            <= r_pc + 8'(PC_STEP);
            r_inflight_addr <= r_pc;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && !J && w_push) begin
         r_mem_data[r_wr_ptr] <= IMEM_DATA;
         r_mem_addr[r_wr_ptr] <= r_inflight_addr;
      end
   end

`ifdef IF_PREFETCH_STATS_EN
   logic [15:0] r_stat_flushes;
   logic [15:0] r_stat_empty;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stat_flushes <= '0;
         r_stat_empty   <= '0;
      end else begin
         if (J && r_stat_flushes != 16'hFFFF)
            r_stat_flushes <= r_stat_flushes + 16'd1;
         if (LE && !w_valid && r_stat_empty != 16'hFFFF)
            r_stat_empty <= r_stat_empty + 16'd1;
      end
   end

   assign STAT_FLUSHES = r_stat_flushes;
   assign STAT_EMPTY   = r_stat_empty;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue; instruction memory returns word = byte address * 3.
module tb_if_prefetch_queue;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        LE  = 1'b0;
   logic        J   = 1'b0;
   logic [7:0]  TA  = 8'h00;
   logic        IMEM_RD;
   logic [7:0]  IMEM_ADDR;
   logic [31:0] IMEM_DATA = 32'h0;
   logic [7:0]  front_address;
   logic [31:0] fetched_instruction;
   logic        VALID;
   logic [2:0]  COUNT;
`ifdef IF_PREFETCH_STATS_EN
   logic [15:0] STAT_FLUSHES;
   logic [15:0] STAT_EMPTY;
`endif

   int checks = 0;
   int errors = 0;

   if_prefetch_queue dut (
      .CLK(CLK), .RST(RST), .LE(LE), .J(J), .TA(TA),
      .IMEM_RD(IMEM_RD), .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
      .front_address(front_address), .fetched_instruction(fetched_instruction),
      .VALID(VALID),
`ifdef IF_PREFETCH_STATS_EN
      .STAT_FLUSHES(STAT_FLUSHES), .STAT_EMPTY(STAT_EMPTY),
`endif
      .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (IMEM_RD) IMEM_DATA <= {24'd0, IMEM_ADDR} * 32'd3;

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic test_reset();
      RST = 1'b1; LE = 1'b0; J = 1'b0; TA = 8'h00;
      tick(); tick(); #1;
      checks++; if (IMEM_RD !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", IMEM_RD); end
      checks++; if (IMEM_ADDR !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", IMEM_ADDR); end
      checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", VALID); end
      checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", COUNT); end
      checks++; if (front_address !== 8'h00) begin errors++; $display("FAIL reset_front got %h exp 00", front_address); end
      checks++; if (fetched_instruction !== 32'h0) begin errors++; $display("FAIL reset_fetched got %h exp 0", fetched_instruction); end
   endtask

   task automatic test_stream();
      RST = 1'b1; LE = 1'b0; tick();
      RST = 1'b0; LE = 1'b1; #1;
      checks++; if (IMEM_RD !== 1'b1 || IMEM_ADDR !== 8'h00 || VALID !== 1'b0) begin
         errors++; $display("FAIL stream_c0 got rd=%b addr=%h valid=%b exp 1/00/0", IMEM_RD, IMEM_ADDR, VALID); end
      tick(); #1;
      checks++; if (IMEM_ADDR !== 8'h04 || VALID !== 1'b0) begin
         errors++; $display("FAIL stream_c1 got addr=%h valid=%b exp 04/0", IMEM_ADDR, VALID); end
      for (int n = 2; n < 8; n++) begin
         tick(); #1;
         checks++;
         if (VALID !== 1'b1 || front_address !== 8'(4*(n-2)) || fetched_instruction !== 32'(12*(n-2))
             || IMEM_ADDR !== 8'(4*n) || COUNT !== 3'd1) begin
            errors++;
            $display("FAIL stream_c%0d got v=%b front=%h data=%h addr=%h cnt=%0d exp 1/%h/%h/%h/1",
                     n, VALID, front_address, fetched_instruction, IMEM_ADDR, COUNT,
                     4*(n-2), 12*(n-2), 4*n);
         end
      end
      LE = 1'b0;
   endtask

   // Leaves the queue full with entries 4,8,12,16 and PC=20 for test_full_stream.
   task automatic test_fill();
      RST = 1'b1; LE = 1'b0; tick();
      RST = 1'b0;
      tick(); tick(); tick(); tick(); #1;
      checks++; if (COUNT !== 3'd3 || IMEM_RD !== 1'b0) begin
         errors++; $display("FAIL fill_e4 got cnt=%0d rd=%b exp 3/0", COUNT, IMEM_RD); end
      tick(); #1;
      checks++; if (COUNT !== 3'd4 || IMEM_RD !== 1'b0 || IMEM_ADDR !== 8'h10) begin
         errors++; $display("FAIL fill_full got cnt=%0d rd=%b addr=%h exp 4/0/10", COUNT, IMEM_RD, IMEM_ADDR); end
      checks++; if (front_address !== 8'h00 || fetched_instruction !== 32'h0) begin
         errors++; $display("FAIL fill_head got front=%h data=%h exp 00/0", front_address, fetched_instruction); end
      LE = 1'b1; tick(); LE = 1'b0; #1;
      checks++; if (COUNT !== 3'd3 || front_address !== 8'h04 || fetched_instruction !== 32'd12
                    || IMEM_RD !== 1'b1 || IMEM_ADDR !== 8'h10) begin
         errors++; $display("FAIL fill_pulse got cnt=%0d front=%h data=%h rd=%b addr=%h exp 3/04/c/1/10",
                            COUNT, front_address, fetched_instruction, IMEM_RD, IMEM_ADDR); end
      tick(); #1;
      checks++; if (COUNT !== 3'd3 || IMEM_RD !== 1'b0) begin
         errors++; $display("FAIL fill_infl got cnt=%0d rd=%b exp 3/0", COUNT, IMEM_RD); end
      tick(); #1;
      checks++; if (COUNT !== 3'd4 || front_address !== 8'h04) begin
         errors++; $display("FAIL fill_refill got cnt=%0d front=%h exp 4/04", COUNT, front_address); end
   endtask

   // Continuous pops from a full queue: heads must step 8,12,16,... with no gap, skip or repeat.
   task automatic test_full_stream();
      LE = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick(); #1;
         checks++;
         if (VALID !== 1'b1 || front_address !== 8'(4*(k+2)) || fetched_instruction !== 32'(12*(k+2))) begin
            errors++;
            $display("FAIL full_stream_%0d got v=%b front=%h data=%h exp 1/%h/%h",
                     k, VALID, front_address, fetched_instruction, 4*(k+2), 12*(k+2));
         end
      end
      LE = 1'b0;
   endtask

   task automatic test_flush();
      RST = 1'b1; LE = 1'b0; tick();
      RST = 1'b0;
      tick(); tick(); tick(); tick();
      J = 1'b1; TA = 8'h40; #1;
      checks++; if (IMEM_RD !== 1'b0 || COUNT !== 3'd3) begin
         errors++; $display("FAIL flush_jcycle got rd=%b cnt=%0d exp 0/3", IMEM_RD, COUNT); end
      tick(); J = 1'b0; LE = 1'b1; #1;
      checks++; if (VALID !== 1'b0 || COUNT !== 3'd0 || front_address !== 8'h40
                    || IMEM_RD !== 1'b1 || IMEM_ADDR !== 8'h40) begin
         errors++; $display("FAIL flush_after got v=%b cnt=%0d front=%h rd=%b addr=%h exp 0/0/40/1/40",
                            VALID, COUNT, front_address, IMEM_RD, IMEM_ADDR); end
      tick(); #1;
      checks++; if (VALID !== 1'b0 || COUNT !== 3'd0) begin
         errors++; $display("FAIL flush_stale got v=%b cnt=%0d exp 0/0", VALID, COUNT); end
      tick(); #1;
      checks++; if (VALID !== 1'b1 || front_address !== 8'h40 || fetched_instruction !== 32'hC0) begin
         errors++; $display("FAIL flush_first got v=%b front=%h data=%h exp 1/40/c0",
                            VALID, front_address, fetched_instruction); end
      tick(); #1;
      checks++; if (front_address !== 8'h44 || fetched_instruction !== 32'hCC) begin
         errors++; $display("FAIL flush_second got front=%h data=%h exp 44/cc", front_address, fetched_instruction); end
      LE = 1'b0;
      J = 1'b1; TA = 8'h80; tick();
      TA = 8'h90; tick(); J = 1'b0; #1;
      checks++; if (IMEM_ADDR !== 8'h90 || COUNT !== 3'd0) begin
         errors++; $display("FAIL flush_double got addr=%h cnt=%0d exp 90/0", IMEM_ADDR, COUNT); end
      tick(); tick(); #1;
      checks++; if (VALID !== 1'b1 || front_address !== 8'h90 || fetched_instruction !== 32'h1B0) begin
         errors++; $display("FAIL flush_double_head got v=%b front=%h data=%h exp 1/90/1b0",
                            VALID, front_address, fetched_instruction); end
   endtask

   task automatic test_wrap();
      logic [7:0]  exp_addr [4];
      logic [31:0] exp_data [4];
      exp_addr = '{8'hF8, 8'hFC, 8'h00, 8'h04};
      exp_data = '{32'h2E8, 32'h2F4, 32'h0, 32'hC};
      J = 1'b1; TA = 8'hF8; LE = 1'b1; tick(); J = 1'b0; #1;
      checks++; if (IMEM_ADDR !== 8'hF8) begin errors++; $display("FAIL wrap_a0 got %h exp f8", IMEM_ADDR); end
      tick(); #1;
      checks++; if (IMEM_ADDR !== 8'hFC) begin errors++; $display("FAIL wrap_a1 got %h exp fc", IMEM_ADDR); end
      for (int k = 0; k < 4; k++) begin
         tick(); #1;
         checks++;
         if (front_address !== exp_addr[k] || fetched_instruction !== exp_data[k] || VALID !== 1'b1) begin
            errors++;
            $display("FAIL wrap_head_%0d got v=%b front=%h data=%h exp 1/%h/%h",
                     k, VALID, front_address, fetched_instruction, exp_addr[k], exp_data[k]);
         end
         if (k < 2) begin
            checks++;
            if (IMEM_ADDR !== exp_addr[k+2]) begin
               errors++; $display("FAIL wrap_addr_%0d got %h exp %h", k, IMEM_ADDR, exp_addr[k+2]);
            end
         end
      end
      LE = 1'b0;
   endtask

   task automatic test_reset_mid();
      RST = 1'b1; LE = 1'b0; tick();
      RST = 1'b0; tick(); tick(); tick(); #1;
      checks++; if (COUNT !== 3'd2) begin errors++; $display("FAIL rstmid_pre got cnt=%0d exp 2", COUNT); end
      RST = 1'b1; #1;
      checks++; if (IMEM_RD !== 1'b0) begin errors++; $display("FAIL rstmid_rd got %b exp 0", IMEM_RD); end
      tick(); #1;
      checks++; if (VALID !== 1'b0 || COUNT !== 3'd0 || IMEM_ADDR !== 8'h00 || front_address !== 8'h00
                    || fetched_instruction !== 32'h0) begin
         errors++; $display("FAIL rstmid_outs got v=%b cnt=%0d addr=%h front=%h data=%h exp 0/0/00/00/0",
                            VALID, COUNT, IMEM_ADDR, front_address, fetched_instruction); end
      RST = 1'b0; tick(); #1;
      checks++; if (VALID !== 1'b0 || COUNT !== 3'd0) begin
         errors++; $display("FAIL rstmid_discard got v=%b cnt=%0d exp 0/0", VALID, COUNT); end
      tick(); #1;
      checks++; if (VALID !== 1'b1 || front_address !== 8'h00 || COUNT !== 3'd1) begin
         errors++; $display("FAIL rstmid_first got v=%b front=%h cnt=%0d exp 1/00/1", VALID, front_address, COUNT); end
   endtask

`ifdef IF_PREFETCH_STATS_EN
   task automatic test_stats();
      RST = 1'b1; LE = 1'b1; J = 1'b0; tick(); tick(); #1;
      checks++; if (STAT_FLUSHES !== 16'd0 || STAT_EMPTY !== 16'd0) begin
         errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", STAT_FLUSHES, STAT_EMPTY); end
      RST = 1'b0; LE = 1'b0; J = 1'b1; TA = 8'h20;
      tick(); tick(); tick();
      J = 1'b0; LE = 1'b1; tick(); tick(); LE = 1'b0; #1;
      checks++; if (STAT_FLUSHES !== 16'd3 || STAT_EMPTY !== 16'd2) begin
         errors++; $display("FAIL stats_count got %0d/%0d exp 3/2", STAT_FLUSHES, STAT_EMPTY); end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_fill();
      test_full_stream();
      test_flush();
      test_wrap();
      test_reset_mid();
`ifdef IF_PREFETCH_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
